// File: rtl/nwd_pkg.sv
// Shared types for the GCD feeder stage: operand word, operand pair and sequencer states.
package nwd_pkg;

    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct packed {
        word_t a;
        word_t b;
    } pair_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [15:0] CYCLES_MAX = 16'hFFFF;

    // Iteration counts stick at the top value instead of wrapping to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CYCLES_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/nwd_fifo.sv
// Small synchronous FIFO of operand pairs; head is visible combinationally so the
// core operand buses always show the oldest queued pair.
module nwd_fifo
#(
    parameter int DEPTH = 4
)
(
    input  logic           clk,
    input  logic           nrst,
    input  logic           push,
    input  nwd_pkg::pair_t data,
    input  logic           pop,
    output logic           full,
    output logic           empty,
    output nwd_pkg::pair_t head
);
    import nwd_pkg::*;

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices coincide.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    pair_t       mem [DEPTH];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/nwd_feeder.sv
// Queues operand pairs and sequences the subtractive GCD core one job at a time.
// WIDTH has to equal nwd_pkg::WIDTH because the queue stores nwd_pkg::pair_t.
module nwd_feeder
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
)
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [15:0]      out_cycles,
    output logic             core_init,
    output logic [WIDTH-1:0] core_in1,
    output logic [WIDTH-1:0] core_in2,
    input  logic [WIDTH-1:0] core_out,
    input  logic             core_fin
);
    import nwd_pkg::*;

    pair_t       head;
    pair_t       push_data;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        zero_head;
    state_t      state_reg;
    logic [15:0] count_reg;

    assign push_data = '{a: in_a, b: in_b};
    assign push      = in_valid && !full;
    assign in_ready  = !full;
    assign core_in1  = head.a;
    assign core_in2  = head.b;
    assign zero_head = (head.a == '0) || (head.b == '0);

    // Zero pairs leave the queue straight from IDLE; real jobs leave when the core latches them.
    assign pop = ((state_reg == IDLE) && !empty && zero_head) || (state_reg == LOAD);

    nwd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .data  (push_data),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            out_valid  <= 1'b0;
            out_gcd    <= '0;
            out_cycles <= '0;
            core_init  <= 1'b0;
        end else begin
            core_init <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        if (zero_head) begin
                            // The core never converges on a zero operand; answer locally.
                            out_gcd    <= head.a | head.b;
                            out_cycles <= '0;
                            out_valid  <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            core_init <= 1'b1;
                            state_reg <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    count_reg <= '0;
                    state_reg <= RUN;
                end
                RUN: begin
                    count_reg <= sat_inc(count_reg);
                    if (core_fin) begin
                        out_gcd    <= core_out;
                        out_cycles <= sat_inc(count_reg);
                        out_valid  <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nwd_feeder.sv
// Bench for nwd_feeder: drives it together with a behavioural subtractive GCD core and
// checks every result against Euclid-based expectations kept in a scoreboard queue.
module tb_nwd_feeder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic [15:0] c;
    } vec_t;

    typedef struct {
        logic [15:0] g;
        logic [15:0] c;
    } res_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_gcd;
    logic [15:0] out_cycles;
    logic        core_init;
    logic [15:0] core_in1;
    logic [15:0] core_in2;
    logic [15:0] core_out;
    logic        core_fin;

    int   checks = 0;
    int   failures = 0;
    int   push_count = 0;
    int   init_cycles = 0;
    int   results_seen = 0;
    int   stall_mark = -1;
    bit   track_stall = 1'b0;
    bit   rnd_done = 1'b0;
    res_t exp_q[$];
    res_t mon_e;
    vec_t tbl[11];

    always #5 clk = ~clk;

    nwd_feeder #(.WIDTH(16), .DEPTH(4)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gcd    (out_gcd),
        .out_cycles (out_cycles),
        .core_init  (core_init),
        .core_in1   (core_in1),
        .core_in2   (core_in2),
        .core_out   (core_out),
        .core_fin   (core_fin)
    );

    // Behavioural subtractive GCD core (no reset, reloads on init).
    logic [15:0] ca;
    logic [15:0] cb;
    always @(posedge clk) begin
        if (core_init) begin
            ca <= core_in1;
            cb <= core_in2;
        end else if (ca > cb) begin
            ca <= ca - cb;
        end else if (cb > ca) begin
            cb <= cb - ca;
        end
    end
    assign core_out = ca;
    assign core_fin = (ca == cb);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // gcd by Euclid; the subtractive core's iteration count equals the sum of the quotients.
    task automatic ref_model(input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] g, output logic [15:0] n);
        int x, y, t, s;
        if (a == 16'd0 || b == 16'd0) begin
            g = a | b;
            n = 16'd0;
        end else begin
            x = int'(a);
            y = int'(b);
            s = 0;
            while (y != 0) begin
                s += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            if (s > 65535) s = 65535;
            g = 16'(x);
            n = 16'(s);
        end
    endtask

    // Result monitor, also tallies init cycles and the first back-pressure stall.
    always @(negedge clk) begin
        if (core_init) init_cycles++;
        if (track_stall && in_valid && !in_ready && stall_mark < 0) stall_mark = push_count;
        if (nrst && out_valid && out_ready) begin
            results_seen++;
            check("result_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("out_gcd", int'(out_gcd), int'(mon_e.g));
                check("out_cycles", int'(out_cycles), int'(mon_e.c));
                $display("result gcd=%0d cycles=%0d expected gcd=%0d cycles=%0d",
                         out_gcd, out_cycles, mon_e.g, mon_e.c);
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] g, input logic [15:0] c);
        int t;
        bit acc;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        check("in_accept", int'(acc), 1);
        if (acc) begin
            exp_q.push_back('{g: g, c: c});
            push_count++;
        end
    endtask

    task automatic drain(input int limit, input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Latency is counted from the IDLE cycle that dispatches the job to the first out_valid cycle.
    task automatic timed_job(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] g, n;
        int t, lat, hi;
        ref_model(a, b, g, n);
        send(a, b, g, n);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!core_init && t < 100);
        lat = 0;
        hi = 0;
        while (!out_valid && lat < 300) begin
            hi += int'(core_init);
            @(negedge clk);
            lat++;
        end
        check("latency_from_idle", lat + 1, 2 + int'(n));
        check("init_pulse_cycles", hi, 1);
        drain(300, "drain_timed");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb, rg, rn;
        int pc0, base, rs0, t;

        tbl[0]  = '{a: 16'd7,    b: 16'd7,  g: 16'd7,  c: 16'd1};
        tbl[1]  = '{a: 16'd0,    b: 16'd9,  g: 16'd9,  c: 16'd0};
        tbl[2]  = '{a: 16'd0,    b: 16'd0,  g: 16'd0,  c: 16'd0};
        tbl[3]  = '{a: 16'd48,   b: 16'd18, g: 16'd6,  c: 16'd5};
        tbl[4]  = '{a: 16'd100,  b: 16'd75, g: 16'd25, c: 16'd4};
        tbl[5]  = '{a: 16'd17,   b: 16'd5,  g: 16'd1,  c: 16'd7};
        tbl[6]  = '{a: 16'd30,   b: 16'd30, g: 16'd30, c: 16'd1};
        tbl[7]  = '{a: 16'd9,    b: 16'd6,  g: 16'd3,  c: 16'd3};
        tbl[8]  = '{a: 16'd1000, b: 16'd10, g: 16'd10, c: 16'd100};
        tbl[9]  = '{a: 16'd21,   b: 16'd14, g: 16'd7,  c: 16'd3};
        tbl[10] = '{a: 16'd8,    b: 16'd4,  g: 16'd4,  c: 16'd2};

        nrst = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_gcd", int'(out_gcd), 0);
        check("rst_out_cycles", int'(out_cycles), 0);
        check("rst_core_init", int'(core_init), 0);
        check("rst_in_ready", int'(in_ready), 1);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        timed_job(16'd12, 16'd8);
        timed_job(16'd7, 16'd7);

        // Back-to-back equal and zero pairs: only the equal pair may reach the core.
        base = init_cycles;
        for (int i = 0; i < 3; i++) send(tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].c);
        drain(200, "drain_zero_pairs");
        check("init_count_zero_pairs", init_cycles - base, 1);

        // Six jobs offered while the first is parked in DONE: queue fills, then all drain in order.
        out_ready = 1'b0;
        pc0 = push_count;
        stall_mark = -1;
        track_stall = 1'b1;
        fork
            begin
                for (int i = 3; i < 9; i++) send(tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].c);
            end
            begin
                repeat (40) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        track_stall = 1'b0;
        check("accepted_before_full", stall_mark - pc0, 5);
        drain(1000, "drain_full");

        // Result held under back-pressure.
        out_ready = 1'b0;
        send(tbl[9].a, tbl[9].b, tbl[9].g, tbl[9].c);
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("hold_reached_done", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_gcd", int'(out_gcd), 7);
            check("hold_cycles", int'(out_cycles), 3);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_valid_dropped", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // Longest job: iteration count reaches the top of the counter without wrapping.
        send(16'd65535, 16'd1, 16'd1, 16'd65535);
        drain(70000, "drain_long");

        // Reset in the middle of a run with two jobs queued behind it.
        ref_model(16'd1000, 16'd3, rg, rn);
        send(16'd1000, 16'd3, rg, rn);
        send(16'd5, 16'd5, 16'd5, 16'd1);
        send(16'd6, 16'd3, 16'd3, 16'd2);
        repeat (20) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_gcd", int'(out_gcd), 0);
        check("midrst_out_cycles", int'(out_cycles), 0);
        check("midrst_core_init", int'(core_init), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        rs0 = results_seen;
        repeat (3) @(negedge clk);
        check("midrst_held_core_init", int'(core_init), 0);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        send(tbl[10].a, tbl[10].b, tbl[10].g, tbl[10].c);
        drain(200, "drain_after_reset");
        repeat (10) @(negedge clk);
        check("no_stale_results", results_seen - rs0, 1);
        @(posedge clk);
        #1;

        // Randomized jobs with random output back-pressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    ra = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 100));
                    rb = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 100));
                    ref_model(ra, rb, rg, rn);
                    send(ra, rb, rg, rn);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                drain(20000, "drain_random");
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
